// File: rtl/button_cpu_cpu_debug_pkg.sv
// button_cpu_cpu_debug_pkg: shared states, jdo field positions and command record for the OCI memory controller
package button_cpu_cpu_debug_pkg;
   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;
   localparam int DEF_TIMEOUT  = 255;
   localparam int JDO_CLR      = 36;
   localparam int JDO_RD       = 35;
   localparam int JDO_WD_MSB   = 34;
   localparam int JDO_WD_LSB   = 3;
   localparam int JDO_ADDR_MSB = 25;
   localparam int JDO_ADDR_LSB = 17;
   localparam int JDO_ADDR_W   = JDO_ADDR_MSB - JDO_ADDR_LSB + 1;
   typedef struct packed {
      logic                  vld;
      logic                  ld;
      logic                  rd;
      logic                  wr;
      logic [JDO_ADDR_W-1:0] addr;
      logic [31:0]           wdata;
   } cmd_t;
endpackage

// File: rtl/button_cpu_cpu_debug_ocimem_ctrl_if.sv
// button_cpu_cpu_debug_ocimem_ctrl_if: OCI memory bus between the debug controller and the memory
interface button_cpu_cpu_debug_ocimem_ctrl_if #(parameter int ADDR_W = 9);
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_read;
   logic              mem_write;
   logic              mem_waitrequest;
   modport master (output mem_addr, mem_wdata, mem_read, mem_write, input mem_waitrequest, mem_rdata);
   modport slave (input mem_addr, mem_wdata, mem_read, mem_write, output mem_waitrequest, mem_rdata);
endinterface

// File: rtl/button_cpu_cpu_debug_ocimem_cmdq.sv
// button_cpu_cpu_debug_ocimem_cmdq: strobe priority select plus a one-deep pending command slot
module button_cpu_cpu_debug_ocimem_cmdq
   import button_cpu_cpu_debug_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [37:0] jdo_i,
   input  logic        take_action_ocimem_a_i,
   input  logic        take_no_action_ocimem_a_i,
   input  logic        take_action_ocimem_b_i,
   input  logic        idle_i,
   output cmd_t        cmd_o,
   output logic        pend_full_o,
   output logic        drop_o,
   output logic        clr_err_o
);
   cmd_t pend_q, pend_d, new_cmd;
   logic sel_a, sel_n, unused_jdo;
   assign unused_jdo = ^{jdo_i[37], jdo_i[2:0]};
   always_comb begin
      sel_a         = take_action_ocimem_a_i & ~take_action_ocimem_b_i;
      sel_n         = take_no_action_ocimem_a_i & ~take_action_ocimem_a_i & ~take_action_ocimem_b_i & jdo_i[JDO_RD];
      new_cmd.vld   = take_action_ocimem_b_i | sel_a | sel_n;
      new_cmd.ld    = sel_a;
      new_cmd.rd    = (sel_a | sel_n) & jdo_i[JDO_RD];
      new_cmd.wr    = take_action_ocimem_b_i;
      new_cmd.addr  = jdo_i[JDO_ADDR_MSB:JDO_ADDR_LSB];
      new_cmd.wdata = jdo_i[JDO_WD_MSB:JDO_WD_LSB];
      // a held command always issues ahead of a fresh one, which then takes the freed slot
      cmd_o         = idle_i ? (pend_q.vld ? pend_q : new_cmd) : '0;
      pend_d        = idle_i ? (pend_q.vld ? new_cmd : '0) : (pend_q.vld ? pend_q : new_cmd);
      drop_o        = ~idle_i & pend_q.vld & new_cmd.vld;
      clr_err_o     = sel_a & jdo_i[JDO_CLR];
      pend_full_o   = pend_q.vld;
   end
   always_ff @(posedge clk) begin
      if (reset) pend_q <= '0;
      else pend_q <= pend_d;
   end
endmodule

// File: rtl/button_cpu_cpu_debug_ocimem_ctrl.sv
// button_cpu_cpu_debug_ocimem_ctrl: debug-port access engine driving the OCI memory bus with timeout
module button_cpu_cpu_debug_ocimem_ctrl
   import button_cpu_cpu_debug_pkg::*;
#(
   parameter int ADDR_W  = 9,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic [37:0]                               jdo,
   input  logic                                      take_action_ocimem_a,
   input  logic                                      take_no_action_ocimem_a,
   input  logic                                      take_action_ocimem_b,
   button_cpu_cpu_debug_ocimem_ctrl_if.master        mem,
   output logic [31:0]                               MonDReg,
   output logic                                      monitor_ready,
   output logic                                      monitor_error,
   output logic                                      busy
);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d, mdr_q, mdr_d;
   logic [7:0]        wcnt_q, wcnt_d;
   logic              ready_q, ready_d, err_q, err_d, tout;
   logic              pend_full, drop, clr_err;
   cmd_t              cmd;
   button_cpu_cpu_debug_ocimem_cmdq u_cmdq (
      .clk                       (clk),
      .reset                     (reset),
      .jdo_i                     (jdo),
      .take_action_ocimem_a_i    (take_action_ocimem_a),
      .take_no_action_ocimem_a_i (take_no_action_ocimem_a),
      .take_action_ocimem_b_i    (take_action_ocimem_b),
      .idle_i                    (state_q == S_IDLE),
      .cmd_o                     (cmd),
      .pend_full_o               (pend_full),
      .drop_o                    (drop),
      .clr_err_o                 (clr_err)
   );
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mdr_d   = mdr_q;
      wcnt_d  = '0;
      ready_d = ready_q;
      tout    = 1'b0;
      case (state_q)
         S_IDLE: if (cmd.vld) begin
            addr_d  = cmd.ld ? ADDR_W'(cmd.addr) : addr_q;
            wdata_d = cmd.wr ? cmd.wdata : wdata_q;
            state_d = cmd.rd ? S_RD : cmd.wr ? S_WR : S_IDLE;
            ready_d = ready_q & ~(cmd.rd | cmd.wr);
         end
         S_RD, S_WR: begin
            tout    = mem.mem_waitrequest & (wcnt_q == 8'(TIMEOUT - 1));
            wcnt_d  = (mem.mem_waitrequest & ~tout) ? wcnt_q + 8'd1 : '0;
            state_d = (~mem.mem_waitrequest | tout) ? S_DONE : state_q;
            mdr_d   = (state_q == S_RD && !mem.mem_waitrequest) ? mem.mem_rdata : mdr_q;
         end
         default: begin
            ready_d = 1'b1;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_IDLE;
         end
      endcase
      // a new error this cycle wins over a simultaneous clear request
      err_d = drop | tout | (err_q & ~clr_err);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         mdr_q   <= '0;
         wcnt_q  <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         mdr_q   <= mdr_d;
         wcnt_q  <= wcnt_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign mem.mem_read  = state_q == S_RD;
   assign mem.mem_write = state_q == S_WR;
   assign MonDReg       = mdr_q;
   assign monitor_ready = ready_q;
   assign monitor_error = err_q;
   assign busy          = state_q != S_IDLE || pend_full;
endmodule

// File: tb/tb_button_cpu_cpu_debug_ocimem_ctrl.sv
// tb_button_cpu_cpu_debug_ocimem_ctrl: scoreboard bench for the OCI memory debug controller
module tb_button_cpu_cpu_debug_ocimem_ctrl;
   typedef struct {
      bit          wr;
      logic [8:0]  addr;
      logic [31:0] data;
   } xfer_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [37:0] jdo = '0;
   logic        st_a = 1'b0, st_n = 1'b0, st_b = 1'b0;
   logic [31:0] MonDReg;
   logic        monitor_ready, monitor_error, busy;
   int          checks = 0, errors = 0, xfers = 0;
   int          wait_n = 0, busc = 0;
   bit          addr_mode = 1'b0;
   logic [31:0] rdata_v = '0;
   xfer_t       exp_q[$];
   bit          in_xfer = 1'b0;
   logic [8:0]  f_addr;
   logic [31:0] f_wd;

   button_cpu_cpu_debug_ocimem_ctrl_if #(.ADDR_W(9)) bus ();

   button_cpu_cpu_debug_ocimem_ctrl #(.ADDR_W(9), .TIMEOUT(255)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .jdo                     (jdo),
      .take_action_ocimem_a    (st_a),
      .take_no_action_ocimem_a (st_n),
      .take_action_ocimem_b    (st_b),
      .mem                     (bus),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error),
      .busy                    (busy)
   );

   always #5 clk = ~clk;

   // memory responder: holds waitrequest for wait_n cycles of each transfer
   always @(posedge clk) busc <= ((bus.mem_read || bus.mem_write) && bus.mem_waitrequest) ? busc + 1 : 0;
   assign bus.mem_waitrequest = (bus.mem_read || bus.mem_write) && busc < wait_n;
   assign bus.mem_rdata = addr_mode ? (32'hA500_0000 | 32'(bus.mem_addr)) : rdata_v;

   // completion monitor: pops the scoreboard on each finished bus transfer
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.mem_read || bus.mem_write) begin
            if (!in_xfer) begin
               in_xfer = 1'b1;
               f_addr = bus.mem_addr;
               f_wd = bus.mem_wdata;
            end
            if (!bus.mem_waitrequest) begin
               in_xfer = 1'b0;
               xfers++;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL xfer_unexpected: got wr=%0b addr=%h wdata=%h, required no transfer", bus.mem_write, bus.mem_addr, bus.mem_wdata);
               end else begin
                  xfer_t e;
                  e = exp_q.pop_front();
                  if (bus.mem_write !== e.wr || bus.mem_read !== !e.wr || bus.mem_addr !== e.addr ||
                      (e.wr && bus.mem_wdata !== e.data) || bus.mem_addr !== f_addr || bus.mem_wdata !== f_wd) begin
                     errors++;
                     $display("FAIL xfer: got rd=%0b wr=%0b addr=%h wdata=%h (first addr=%h wdata=%h), required wr=%0b addr=%h wdata=%h",
                              bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata, f_addr, f_wd, e.wr, e.addr, e.data);
                  end
               end
            end
         end else in_xfer = 1'b0;
      end
   end

   function automatic logic [37:0] mk_a(input bit clr, input bit rd, input logic [8:0] a);
      logic [37:0] j;
      j = '0;
      j[36] = clr;
      j[35] = rd;
      j[25:17] = a;
      return j;
   endfunction

   function automatic logic [37:0] mk_b(input logic [31:0] wd);
      logic [37:0] j;
      j = '0;
      j[34:3] = wd;
      return j;
   endfunction

   // called at a negedge; the strobe is seen by exactly one rising edge
   task automatic strobe(input bit a, input bit n, input bit b, input logic [37:0] j);
      st_a = a;
      st_n = n;
      st_b = b;
      jdo = j;
      @(negedge clk);
      st_a = 1'b0;
      st_n = 1'b0;
      st_b = 1'b0;
      jdo = '0;
   endtask

   task automatic wait_idle(input int max, output bit ok);
      int n = 0;
      while (busy === 1'b1 && n < max) begin
         @(negedge clk);
         n++;
      end
      ok = (busy === 1'b0);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (MonDReg !== 32'h0 || monitor_ready !== 1'b0 || monitor_error !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_status: MonDReg=%h ready=%b error=%b busy=%b, required 0 0 0 0", MonDReg, monitor_ready, monitor_error, busy);
      end
      checks++;
      if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_addr !== 9'h0 || bus.mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_bus: rd=%b wr=%b addr=%h wdata=%h, required all 0", bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_read;
      bit ok;
      wait_n = 0;
      addr_mode = 1'b0;
      rdata_v = 32'hDEADBEEF;
      exp_q.push_back('{1'b0, 9'h010, 32'h0});
      strobe(1, 0, 0, mk_a(0, 1, 9'h010));
      checks++;
      if (bus.mem_read !== 1'b1 || bus.mem_addr !== 9'h010 || busy !== 1'b1) begin
         errors++;
         $display("FAIL read_issue: rd=%b addr=%h busy=%b, required 1 010 1", bus.mem_read, bus.mem_addr, busy);
      end
      @(negedge clk);
      checks++;
      if (bus.mem_read !== 1'b0 || MonDReg !== 32'hDEADBEEF || monitor_ready !== 1'b0) begin
         errors++;
         $display("FAIL read_done: rd=%b MonDReg=%h ready=%b, required 0 deadbeef 0", bus.mem_read, MonDReg, monitor_ready);
      end
      @(negedge clk);
      checks++;
      if (monitor_ready !== 1'b1 || bus.mem_addr !== 9'h011 || busy !== 1'b0) begin
         errors++;
         $display("FAIL read_ready: ready=%b addr=%h busy=%b, required 1 011 0", monitor_ready, bus.mem_addr, busy);
      end
      rdata_v = 32'hCAFEF00D;
      exp_q.push_back('{1'b0, 9'h011, 32'h0});
      strobe(0, 1, 0, mk_a(0, 1, 9'h000));
      checks++;
      if (monitor_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_clear: ready=%b, required 0", monitor_ready);
      end
      wait_idle(20, ok);
      checks++;
      if (!ok || MonDReg !== 32'hCAFEF00D || bus.mem_addr !== 9'h012 || monitor_ready !== 1'b1) begin
         errors++;
         $display("FAIL noaction_read: idle=%b MonDReg=%h addr=%h ready=%b, required 1 cafef00d 012 1", ok, MonDReg, bus.mem_addr, monitor_ready);
      end
   endtask

   task automatic test_write_wrap;
      int n = 0;
      strobe(1, 0, 0, mk_a(0, 0, 9'h1FF));
      checks++;
      if (bus.mem_addr !== 9'h1FF || busy !== 1'b0 || bus.mem_read !== 1'b0 || monitor_ready !== 1'b1) begin
         errors++;
         $display("FAIL addr_load: addr=%h busy=%b rd=%b ready=%b, required 1ff 0 0 1", bus.mem_addr, busy, bus.mem_read, monitor_ready);
      end
      wait_n = 4;
      exp_q.push_back('{1'b1, 9'h1FF, 32'h12345678});
      strobe(0, 0, 1, mk_b(32'h12345678));
      while (bus.mem_write === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != 5) begin
         errors++;
         $display("FAIL write_len: mem_write cycles=%0d, required 5", n);
      end
      @(negedge clk);
      checks++;
      if (bus.mem_addr !== 9'h000 || monitor_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL addr_wrap: addr=%h ready=%b busy=%b, required 000 1 0", bus.mem_addr, monitor_ready, busy);
      end
   endtask

   task automatic test_priority;
      bit ok;
      int x0;
      logic [37:0] j;
      wait_n = 0;
      x0 = xfers;
      exp_q.push_back('{1'b1, 9'h000, 32'hA1B2C3D4});
      j = mk_b(32'hA1B2C3D4);
      j[35] = 1'b1;
      strobe(0, 1, 1, j);
      wait_idle(20, ok);
      repeat (2) @(negedge clk);
      checks++;
      if (!ok || xfers - x0 != 1 || exp_q.size() != 0 || bus.mem_addr !== 9'h001 || MonDReg !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL priority: idle=%b xfers=%0d left=%0d addr=%h MonDReg=%h, required 1 1 0 001 cafef00d",
                  ok, xfers - x0, exp_q.size(), bus.mem_addr, MonDReg);
      end
   endtask

   task automatic test_timeout;
      bit ok;
      int n = 0;
      wait_n = 1000;
      strobe(1, 0, 0, mk_a(0, 1, 9'h020));
      while (bus.mem_read === 1'b1 && n < 400) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != 255) begin
         errors++;
         $display("FAIL timeout_len: mem_read cycles=%0d, required 255", n);
      end
      checks++;
      if (bus.mem_read !== 1'b0 || monitor_error !== 1'b1 || MonDReg !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL timeout_abort: rd=%b error=%b MonDReg=%h, required 0 1 cafef00d", bus.mem_read, monitor_error, MonDReg);
      end
      wait_idle(10, ok);
      wait_n = 0;
      strobe(1, 0, 0, mk_a(1, 0, 9'h040));
      checks++;
      if (!ok || monitor_error !== 1'b0 || bus.mem_addr !== 9'h040) begin
         errors++;
         $display("FAIL error_clear: idle=%b error=%b addr=%h, required 1 0 040", ok, monitor_error, bus.mem_addr);
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      addr_mode = 1'b1;
      wait_n = 3;
      exp_q.push_back('{1'b0, 9'h040, 32'h0});
      exp_q.push_back('{1'b0, 9'h041, 32'h0});
      strobe(1, 0, 0, mk_a(0, 1, 9'h040));
      strobe(0, 1, 0, mk_a(0, 1, 9'h000));
      strobe(0, 0, 1, mk_b(32'h0BAD0BAD));
      checks++;
      if (monitor_error !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL drop_error: error=%b busy=%b, required 1 1", monitor_error, busy);
      end
      wait_idle(60, ok);
      checks++;
      if (!ok || exp_q.size() != 0 || MonDReg !== 32'hA500_0041 || bus.mem_addr !== 9'h042 || monitor_error !== 1'b1) begin
         errors++;
         $display("FAIL queued_issue: idle=%b left=%0d MonDReg=%h addr=%h error=%b, required 1 0 a5000041 042 1",
                  ok, exp_q.size(), MonDReg, bus.mem_addr, monitor_error);
      end
   endtask

   task automatic test_reset_mid;
      int bad = 0;
      addr_mode = 1'b0;
      wait_n = 1000;
      strobe(1, 0, 0, mk_a(0, 1, 9'h055));
      strobe(0, 1, 0, mk_a(0, 1, 9'h000));
      checks++;
      if (bus.mem_read !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_setup: rd=%b busy=%b, required 1 1", bus.mem_read, busy);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || busy !== 1'b0 || bus.mem_addr !== 9'h0 ||
          bus.mem_wdata !== 32'h0 || MonDReg !== 32'h0 || monitor_ready !== 1'b0 || monitor_error !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: rd=%b wr=%b busy=%b addr=%h wdata=%h MonDReg=%h ready=%b error=%b, required all 0",
                  bus.mem_read, bus.mem_write, busy, bus.mem_addr, bus.mem_wdata, MonDReg, monitor_ready, monitor_error);
      end
      reset = 1'b0;
      wait_n = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.mem_read !== 1'b0 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL pend_discard: cycles with activity=%0d, required 0", bad);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_read();
      test_write_wrap();
      test_priority();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left: pending=%0d, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/button_cpu_cpu_debug_ocimem_ctrl.md
BUTTON_CPU_CPU_DEBUG_OCIMEM_CTRL -- requirements
Module: button_cpu_cpu_debug_ocimem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, OCI memory word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum waitrequest cycles before a transfer is aborted.
REQ-003 SHALL have port clk  in  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port jdo  in  38  debug command payload: addr=jdo[25:17], wdata=jdo[34:3], rd=jdo[35].
REQ-006 SHALL have port take_action_ocimem_a  in  1  single-cycle strobe: load address; read if rd=1.
REQ-007 SHALL have port take_no_action_ocimem_a  in  1  single-cycle strobe: read at current address if rd=1.
REQ-008 SHALL have port take_action_ocimem_b  in  1  single-cycle strobe: write wdata at current address.
REQ-009 SHALL have ports mem_addr out ADDR_W, mem_wdata out 32, mem_read out 1, mem_write out 1, mem_waitrequest in 1, mem_rdata in 32.
REQ-010 SHALL have ports MonDReg out 32 (read data), monitor_ready out 1, monitor_error out 1 (sticky), busy out 1.

Function
REQ-011 Strobe priority on the same cycle SHALL be ocimem_b > ocimem_a > no_action_ocimem_a; lower-priority strobes that cycle are discarded.
REQ-012 A strobe with rd=0 on ocimem_a SHALL only load the address (1 cycle, no bus access, monitor_ready unchanged).
REQ-013 States SHALL be IDLE, RD (mem_read=1), WR (mem_write=1), DONE.
REQ-014 IDLE -> RD/WR on the cycle after an accepted command; mem_addr/mem_wdata SHALL be registered and stable throughout RD/WR.
REQ-015 RD/WR -> DONE on the first cycle with mem_waitrequest=0; in RD, MonDReg SHALL capture mem_rdata that cycle.
REQ-016 DONE -> IDLE after exactly 1 cycle; in DONE monitor_ready SHALL be set to 1 and the address incremented by 1.
REQ-017 Address increment SHALL wrap from 2^ADDR_W-1 to 0.
REQ-018 monitor_ready SHALL clear to 0 on the cycle a bus command is accepted.
REQ-019 Minimum command-to-ready latency SHALL be 3 cycles (accept, RD/WR with waitrequest=0, DONE).
REQ-020 An 8-bit wait counter SHALL count RD/WR cycles with waitrequest=1; on reaching TIMEOUT, the FSM SHALL deassert mem_read/mem_write, go to DONE, leave MonDReg unchanged and set monitor_error.
REQ-021 A one-deep pending-command register SHALL hold one command arriving while busy; it issues in the IDLE cycle after DONE.
REQ-022 A command arriving while the pending register is full SHALL be dropped and SHALL set monitor_error.
REQ-023 monitor_error SHALL clear only when take_action_ocimem_a is accepted with jdo[36]=1.
REQ-024 busy SHALL be 1 whenever state != IDLE or the pending register is full.
REQ-025 mem_read and mem_write SHALL never both be 1.

Reset
REQ-026 Reset SHALL force state=IDLE, address=0, pending empty, wait counter=0.
REQ-027 Reset values: MonDReg=0, monitor_ready=0, monitor_error=0, busy=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-028 Reset asserted mid-transfer SHALL drop mem_read/mem_write the following cycle and discard the pending command.

Structure
REQ-029 State enum, jdo field bit positions and default TIMEOUT SHALL live in shared package button_cpu_cpu_debug_pkg.
REQ-030 The pending-command register with priority select SHALL be sub-module button_cpu_cpu_debug_ocimem_cmdq.

Verification
REQ-031 ocimem_a addr=0x010 rd=1, waitrequest=0, rdata=0xDEADBEEF -> mem_read 1 cycle at 0x010; MonDReg=0xDEADBEEF; monitor_ready=1 three cycles after strobe; address=0x011.
REQ-032 ocimem_b wdata=0x12345678 at address 0x1FF, waitrequest=1 for 4 cycles -> mem_write held 5 cycles with stable data; address wraps to 0x000.
REQ-033 Read with waitrequest held high -> abort after 255 wait cycles; monitor_error=1; MonDReg unchanged; mem_read=0 next cycle.
REQ-034 ocimem_b and no_action_ocimem_a on the same cycle -> only the write issues.
REQ-035 Three strobes while busy -> second queued and issued after DONE; third dropped; monitor_error=1.
REQ-036 Reset asserted in RD -> mem_read=0, pending empty, all outputs at reset values next cycle.
